dl_symb_depkg: RTL and testbench
================================

# dl_symb_depkg

Receive-side counterpart of the downlink symbol transmit path. Accepts the 64-bit CPRI IQ word stream, hunts for packet headers, recovers the per-packet antenna/slot/symbol/PRB metadata and expands block-floating-point 14-bit I/Q samples back to 16-bit I/Q using the packet shift. It sits directly after the CPRI RX word interface and feeds downstream RE consumers with two REs per cycle.

## Interface
- MAX_WORDS, 96, largest legal payload word count per packet (header length field is 7 bits)
- SYNC, 8'hA5, header sync byte
- clk  in  1  single clock, 368.64 MHz domain
- rst_n  in  1  asynchronous, active-low reset
- i_iq_rx_valid  in  1  input word qualifier; no backpressure
- i_iq_rx_data  in  64  CPRI word, header or payload
- o_vld  out  1  RE pair valid
- o_sop / o_eop  out  1  first / last RE pair of a packet
- o_re0 / o_re1  out  32  {I[15:0],Q[15:0]} expanded REs (re0 = even RE)
- o_ch_type  out  4; o_cell_idx  out  1; o_ant_idx  out  2; o_slot_idx  out  7; o_symb_idx  out  4; o_prb_idx  out  9; o_info  out  8; o_shift  out  4  header fields of the current packet, held until next accepted header
- o_hdr_err  out  1  one-cycle pulse: sync matched but length illegal
- o_drop_cnt  out  16  saturating count of valid words discarded while hunting

## Operation
- Header word: [63:56] sync, [55:52] ch_type, [51] cell_idx, [50:49] ant_idx, [48:42] slot_idx, [41:38] symb_idx, [37:29] prb_idx, [28:21] info, [20:17] shift, [16:10] payload word count LEN, [9:0] reserved (ignored).
- Payload word: [59:46] I0, [45:32] Q0, [27:14] I1, [13:0] Q1, two's complement; bits [63:60],[31:28] ignored.
- FSM HUNT: valid word with [63:56]==SYNC and 1<=LEN<=MAX_WORDS -> latch fields, load counter=LEN, go PAYLOAD. Sync match with LEN==0 or LEN>MAX_WORDS -> pulse o_hdr_err, stay HUNT, do not count as drop. Any other valid word -> o_drop_cnt+1 (saturate at 16'hFFFF).
- FSM PAYLOAD: every valid word is payload regardless of content (sync byte not re-checked); emits one RE pair; counter decrements; word with counter==1 gets eop and returns to HUNT. Idle cycles (valid low) hold state.
- LEN==1: single output beat with sop and eop both high.
- Expansion per component: y = sext16(x) <<< shift, saturated to [-32768, 32767]; shift 0..15 all legal.
- Header fields update on the cycle the header's first payload beat appears at the output (aligned with o_sop), never mid-packet.

## Timing
- Latency: payload word at input cycle n -> RE pair at output cycle n+2 (stage 1 parse/field capture, stage 2 shift/saturate, registered outputs).
- Header word produces no output beat; header at n, first payload at n+1 -> o_sop at n+3.
- Back-to-back packets: header immediately after previous eop word accepted with no bubble.
- Reset: all outputs 0, o_drop_cnt 0, FSM HUNT, counters clear; reset mid-packet discards the packet, no eop emitted; pipeline contents flushed.
- o_hdr_err asserted at n+1 for an illegal header at n.

## Structure
- Shared package dl_symb_pkg: SYNC, header bit-position localparams, MAX_WORDS, state enum {HUNT, PAYLOAD}; transmit packer uses the same constants.
- One sub-module dl_symb_bfp_expand: combinational 14-bit + 4-bit shift -> saturated 16-bit; instantiated four times (I0,Q0,I1,Q1) in stage 2.

## Test plan
- Header LEN=6, shift=0, six payload words with I0=14'h1FFF,Q0=14'h2000 -> six beats, sop on 1st, eop on 6th, re0={16'h1FFF,16'hE000}, latency 2 from each payload word.
- shift=3, I0=14'h0400 (1024) -> 16'h2000; I0=14'h1000 (4096) -> saturate 16'h7FFF; I0=14'h2000 (-8192) -> 16'h8000.
- Five junk words then valid header LEN=1 -> o_drop_cnt=5, single beat with sop=eop=1, fields match header.
- Header with LEN=0, then LEN=97 -> two o_hdr_err pulses, no output, o_drop_cnt unchanged; next legal packet decodes normally.
- Two back-to-back packets (ant_idx 0 then 3, LEN=2) with payload containing 8'hA5 in [63:56] and idle gaps -> 4 beats, payload not treated as header, o_ant_idx switches exactly at second sop.
- Assert rst_n low after 3 of 6 payload words -> outputs zero asynchronously, no eop; after release, new packet decodes from HUNT.

Source files
------------

// File: rtl/dl_symb_pkg.sv
// Shared downlink symbol packet constants: sync byte, header/payload bit
// positions, legal payload length and the receive state encoding.
package dl_symb_pkg;

    localparam logic [7:0]  SYNC      = 8'hA5;
    localparam int unsigned MAX_WORDS = 96;

    localparam int unsigned LEN_W  = 7;
    localparam int unsigned SAMP_W = 14;

    // Header word bit positions (LSB of each field)
    localparam int unsigned HDR_SYNC_LSB  = 56;
    localparam int unsigned HDR_CH_LSB    = 52;
    localparam int unsigned HDR_CELL_LSB  = 51;
    localparam int unsigned HDR_ANT_LSB   = 49;
    localparam int unsigned HDR_SLOT_LSB  = 42;
    localparam int unsigned HDR_SYMB_LSB  = 38;
    localparam int unsigned HDR_PRB_LSB   = 29;
    localparam int unsigned HDR_INFO_LSB  = 21;
    localparam int unsigned HDR_SHIFT_LSB = 17;
    localparam int unsigned HDR_LEN_LSB   = 10;

    // Payload word bit positions (LSB of each 14-bit sample)
    localparam int unsigned PL_I0_LSB = 46;
    localparam int unsigned PL_Q0_LSB = 32;
    localparam int unsigned PL_I1_LSB = 14;
    localparam int unsigned PL_Q1_LSB = 0;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    // Field order matches header bits [55:17] so a straight slice casts in
    typedef struct packed {
        logic [3:0] ch_type;
        logic       cell_idx;
        logic [1:0] ant_idx;
        logic [6:0] slot_idx;
        logic [3:0] symb_idx;
        logic [8:0] prb_idx;
        logic [7:0] info;
        logic [3:0] shift;
    } hdr_t;

    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (32'(len) <= MAX_WORDS);
    endfunction

endpackage

// File: rtl/dl_symb_bfp_expand.sv
// Block-floating-point expander: 14-bit two's complement sample shifted
// left by the packet exponent and saturated to signed 16 bits.
module dl_symb_bfp_expand
    import dl_symb_pkg::*;
(
    input  logic [SAMP_W-1:0] i_samp,
    input  logic [3:0]        i_shift,
    output logic [15:0]       o_samp
);

    logic signed [31:0] w_wide;
    logic signed [31:0] w_shifted;

    // 32 bits holds the worst case 2^13 << 15 without overflow
    assign w_wide    = {{(32-SAMP_W){i_samp[SAMP_W-1]}}, i_samp};
    assign w_shifted = w_wide <<< i_shift;

    // Clamp the widened result into the signed 16-bit range
    always_comb begin
        if (w_shifted > 32'sd32767) begin
            o_samp = 16'h7FFF;
        end else if (w_shifted < -32'sd32768) begin
            o_samp = 16'h8000;
        end else begin
            o_samp = w_shifted[15:0];
        end
    end

endmodule

// File: rtl/dl_symb_depkg.sv
// Downlink symbol depacketiser: hunts CPRI words for headers, captures the
// packet metadata and expands BFP payload into two 16-bit I/Q REs per beat.
module dl_symb_depkg
    import dl_symb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_iq_rx_valid,
    input  logic [63:0] i_iq_rx_data,
    output logic        o_vld,
    output logic        o_sop,
    output logic        o_eop,
    output logic [31:0] o_re0,
    output logic [31:0] o_re1,
    output logic [3:0]  o_ch_type,
    output logic        o_cell_idx,
    output logic [1:0]  o_ant_idx,
    output logic [6:0]  o_slot_idx,
    output logic [3:0]  o_symb_idx,
    output logic [8:0]  o_prb_idx,
    output logic [7:0]  o_info,
    output logic [3:0]  o_shift,
    output logic        o_hdr_err,
    output logic [15:0] o_drop_cnt
);

    state_t            r_state;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_first;
    hdr_t              r_hdr;
    logic              r_hdr_err;
    logic [15:0]       r_drop_cnt;

    // Stage 1: parsed payload beat plus the metadata of its packet
    logic              r_s1_vld;
    logic              r_s1_sop;
    logic              r_s1_eop;
    logic [SAMP_W-1:0] r_s1_i0, r_s1_q0, r_s1_i1, r_s1_q1;
    hdr_t              r_s1_hdr;

    // Stage 2: registered outputs
    logic              r_vld, r_sop, r_eop;
    logic [31:0]       r_re0, r_re1;
    hdr_t              r_out_hdr;

    logic              w_sync_hit;
    logic              w_len_ok;
    logic [15:0]       w_i0, w_q0, w_i1, w_q1;

    assign w_sync_hit = (i_iq_rx_data[HDR_SYNC_LSB +: 8] == SYNC);
    assign w_len_ok   = len_legal(i_iq_rx_data[HDR_LEN_LSB +: LEN_W]);

    // Header hunt / payload count FSM, also captures stage-1 payload beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_hdr      <= '0;
            r_hdr_err  <= 1'b0;
            r_drop_cnt <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_s1_i0    <= '0;
            r_s1_q0    <= '0;
            r_s1_i1    <= '0;
            r_s1_q1    <= '0;
            r_s1_hdr   <= '0;
        end else begin
            r_hdr_err <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s1_sop  <= 1'b0;
            r_s1_eop  <= 1'b0;
            if (i_iq_rx_valid) begin
                case (r_state)
                    HUNT: begin
                        if (w_sync_hit && w_len_ok) begin
                            r_hdr   <= hdr_t'(i_iq_rx_data[HDR_CH_LSB+3 : HDR_SHIFT_LSB]);
                            r_cnt   <= i_iq_rx_data[HDR_LEN_LSB +: LEN_W];
                            r_first <= 1'b1;
                            r_state <= PAYLOAD;
                        end else if (w_sync_hit) begin
                            r_hdr_err <= 1'b1;
                        end else if (r_drop_cnt != 16'hFFFF) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                    end
                    PAYLOAD: begin
                        r_s1_vld <= 1'b1;
                        r_s1_sop <= r_first;
                        r_s1_eop <= (r_cnt == LEN_W'(1));
                        r_s1_i0  <= i_iq_rx_data[PL_I0_LSB +: SAMP_W];
                        r_s1_q0  <= i_iq_rx_data[PL_Q0_LSB +: SAMP_W];
                        r_s1_i1  <= i_iq_rx_data[PL_I1_LSB +: SAMP_W];
                        r_s1_q1  <= i_iq_rx_data[PL_Q1_LSB +: SAMP_W];
                        // Metadata rides with each beat so a following header
                        // cannot disturb the packet still in flight
                        r_s1_hdr <= r_hdr;
                        r_first  <= 1'b0;
                        r_cnt    <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= HUNT;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    dl_symb_bfp_expand u_exp_i0 (.i_samp(r_s1_i0), .i_shift(r_s1_hdr.shift), .o_samp(w_i0));
    dl_symb_bfp_expand u_exp_q0 (.i_samp(r_s1_q0), .i_shift(r_s1_hdr.shift), .o_samp(w_q0));
    dl_symb_bfp_expand u_exp_i1 (.i_samp(r_s1_i1), .i_shift(r_s1_hdr.shift), .o_samp(w_i1));
    dl_symb_bfp_expand u_exp_q1 (.i_samp(r_s1_q1), .i_shift(r_s1_hdr.shift), .o_samp(w_q1));

    // Stage 2: register expanded REs; header fields switch only on sop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_re0     <= '0;
            r_re1     <= '0;
            r_out_hdr <= '0;
        end else begin
            r_vld <= r_s1_vld;
            r_sop <= r_s1_sop;
            r_eop <= r_s1_eop;
            if (r_s1_vld) begin
                r_re0 <= {w_i0, w_q0};
                r_re1 <= {w_i1, w_q1};
            end
            if (r_s1_sop) begin
                r_out_hdr <= r_s1_hdr;
            end
        end
    end

    assign o_vld      = r_vld;
    assign o_sop      = r_sop;
    assign o_eop      = r_eop;
    assign o_re0      = r_re0;
    assign o_re1      = r_re1;
    assign o_ch_type  = r_out_hdr.ch_type;
    assign o_cell_idx = r_out_hdr.cell_idx;
    assign o_ant_idx  = r_out_hdr.ant_idx;
    assign o_slot_idx = r_out_hdr.slot_idx;
    assign o_symb_idx = r_out_hdr.symb_idx;
    assign o_prb_idx  = r_out_hdr.prb_idx;
    assign o_info     = r_out_hdr.info;
    assign o_shift    = r_out_hdr.shift;
    assign o_hdr_err  = r_hdr_err;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_dl_symb_depkg.sv
// Directed bench for dl_symb_depkg: header hunting, BFP expansion,
// length boundaries, back-to-back packets and mid-packet reset.
module tb_dl_symb_depkg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_iq_rx_valid = 1'b0;
    logic [63:0] i_iq_rx_data = '0;
    logic        o_vld, o_sop, o_eop;
    logic [31:0] o_re0, o_re1;
    logic [3:0]  o_ch_type;
    logic        o_cell_idx;
    logic [1:0]  o_ant_idx;
    logic [6:0]  o_slot_idx;
    logic [3:0]  o_symb_idx;
    logic [8:0]  o_prb_idx;
    logic [7:0]  o_info;
    logic [3:0]  o_shift;
    logic        o_hdr_err;
    logic [15:0] o_drop_cnt;

    int n_checks = 0;
    int n_err    = 0;

    logic [38:0] w_fields;
    assign w_fields = {o_ch_type, o_cell_idx, o_ant_idx, o_slot_idx, o_symb_idx,
                       o_prb_idx, o_info, o_shift};

    always #5 clk = ~clk;

    dl_symb_depkg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_iq_rx_valid (i_iq_rx_valid),
        .i_iq_rx_data  (i_iq_rx_data),
        .o_vld         (o_vld),
        .o_sop         (o_sop),
        .o_eop         (o_eop),
        .o_re0         (o_re0),
        .o_re1         (o_re1),
        .o_ch_type     (o_ch_type),
        .o_cell_idx    (o_cell_idx),
        .o_ant_idx     (o_ant_idx),
        .o_slot_idx    (o_slot_idx),
        .o_symb_idx    (o_symb_idx),
        .o_prb_idx     (o_prb_idx),
        .o_info        (o_info),
        .o_shift       (o_shift),
        .o_hdr_err     (o_hdr_err),
        .o_drop_cnt    (o_drop_cnt)
    );

    // Fields packed as {ch,cell,ant,slot,symb,prb,info,shift}; reserved bits nonzero
    function automatic logic [63:0] mk_hdr(input logic [38:0] f, input logic [6:0] len);
        return {8'hA5, f, len, 10'h2AA};
    endfunction

    function automatic logic [63:0] mk_pl(input logic [13:0] i0, input logic [13:0] q0,
                                          input logic [13:0] i1, input logic [13:0] q1);
        return {4'h0, i0, q0, 4'h0, i1, q1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic sop, input logic eop,
                            input logic [31:0] re0, input logic [31:0] re1);
        chk({tag, ".vld"}, 64'(o_vld), 64'(1'b1));
        chk({tag, ".sop"}, 64'(o_sop), 64'(sop));
        chk({tag, ".eop"}, 64'(o_eop), 64'(eop));
        chk({tag, ".re0"}, 64'(o_re0), 64'(re0));
        chk({tag, ".re1"}, 64'(o_re1), 64'(re1));
    endtask

    // Present one input word, then wait until just after the sampling edge
    task automatic cyc(input logic v, input logic [63:0] d);
        i_iq_rx_valid = v;
        i_iq_rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Invalid cycle carrying a sync-looking word that must be ignored
    task automatic idle();
        cyc(1'b0, 64'hA5A5_A5A5_A5A5_A5A5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [38:0] F1  = {4'h3, 1'b1, 2'd2, 7'd45, 4'd9, 9'd300, 8'h5C, 4'd0};
    localparam logic [38:0] F2  = {4'h1, 1'b0, 2'd1, 7'd3, 4'd2, 9'd17, 8'h00, 4'd3};
    localparam logic [38:0] F3  = {4'hA, 1'b0, 2'd1, 7'd127, 4'd13, 9'd511, 8'hFF, 4'd15};
    localparam logic [38:0] F4  = {4'h7, 1'b1, 2'd3, 7'd64, 4'd0, 9'd0, 8'h81, 4'd1};
    localparam logic [38:0] F5A = {4'h2, 1'b0, 2'd0, 7'd10, 4'd1, 9'd5, 8'h11, 4'd0};
    localparam logic [38:0] F5B = {4'h2, 1'b0, 2'd3, 7'd10, 4'd1, 9'd5, 8'h11, 4'd0};
    localparam logic [38:0] F6  = {4'h5, 1'b1, 2'd2, 7'd1, 4'd3, 9'd7, 8'h42, 4'd0};

    logic [63:0] pa5;

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.vld", 64'(o_vld), 64'(1'b0));
        chk("rst.sop", 64'(o_sop), 64'(1'b0));
        chk("rst.eop", 64'(o_eop), 64'(1'b0));
        chk("rst.re0", 64'(o_re0), 64'(32'h0));
        chk("rst.re1", 64'(o_re1), 64'(32'h0));
        chk("rst.fields", 64'(w_fields), 64'(39'h0));
        chk("rst.hdr_err", 64'(o_hdr_err), 64'(1'b0));
        chk("rst.drop", 64'(o_drop_cnt), 64'(16'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- LEN=6, shift=0 ----------------
        cyc(1'b1, mk_hdr(F1, 7'd6));
        chk("t1.hdr_no_beat", 64'(o_vld), 64'(1'b0));
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, mk_pl(14'h1FFF, 14'h2000, 14'(k), 14'h3FFF));
            if (k == 0) begin
                chk("t1.latency", 64'(o_vld), 64'(1'b0));
            end else begin
                chk_beat($sformatf("t1.b%0d", k - 1), (k == 1), 1'b0,
                         {16'h1FFF, 16'hE000}, {16'(k - 1), 16'hFFFF});
            end
            if (k == 1) chk("t1.fields", 64'(w_fields), 64'(F1));
        end
        idle();
        chk_beat("t1.b5", 1'b0, 1'b1, {16'h1FFF, 16'hE000}, {16'd5, 16'hFFFF});
        idle();
        chk("t1.after_eop", 64'(o_vld), 64'(1'b0));
        chk("t1.fields_hold", 64'(w_fields), 64'(F1));
        chk("t1.drop", 64'(o_drop_cnt), 64'(16'd0));

        // ---------------- shift=3 expansion and saturation ----------------
        cyc(1'b1, mk_hdr(F2, 7'd3));
        cyc(1'b1, mk_pl(14'h0400, 14'h0000, 14'h3FFF, 14'h0001));
        cyc(1'b1, mk_pl(14'h1000, 14'h2000, 14'h1FFF, 14'h3000));
        chk_beat("t2.b0", 1'b1, 1'b0, {16'h2000, 16'h0000}, {16'hFFF8, 16'h0008});
        chk("t2.fields", 64'(w_fields), 64'(F2));
        cyc(1'b1, mk_pl(14'h2000, 14'h0FFF, 14'h0000, 14'h3001));
        chk_beat("t2.b1", 1'b0, 1'b0, {16'h7FFF, 16'h8000}, {16'h7FFF, 16'h8000});
        idle();
        chk_beat("t2.b2", 1'b0, 1'b1, {16'h8000, 16'h7FF8}, {16'h0000, 16'h8008});

        // ---------------- junk words, then LEN=1 with shift=15 ----------------
        cyc(1'b1, 64'h0000_0000_0000_0000);
        cyc(1'b1, 64'hA400_0000_0000_0400);
        cyc(1'b1, 64'h25A5_A5A5_A5A5_A5A5);
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1'b1, 64'h5A00_0000_0000_0400);
        chk("t3.drop5", 64'(o_drop_cnt), 64'(16'd5));
        chk("t3.no_beat", 64'(o_vld), 64'(1'b0));
        cyc(1'b1, mk_hdr(F3, 7'd1));
        chk("t3.hdr_ok", 64'(o_hdr_err), 64'(1'b0));
        chk("t3.drop_hold", 64'(o_drop_cnt), 64'(16'd5));
        cyc(1'b1, mk_pl(14'h0001, 14'h3FFF, 14'h0000, 14'h0000));
        chk("t3.latency", 64'(o_vld), 64'(1'b0));
        idle();
        chk_beat("t3.b0", 1'b1, 1'b1, {16'h7FFF, 16'h8000}, 32'h0);
        chk("t3.fields", 64'(w_fields), 64'(F3));
        idle();
        chk("t3.single", 64'(o_vld), 64'(1'b0));

        // ---------------- illegal lengths ----------------
        cyc(1'b1, mk_hdr(F1, 7'd0));
        chk("t4.err_len0", 64'(o_hdr_err), 64'(1'b1));
        cyc(1'b1, mk_hdr(F1, 7'd97));
        chk("t4.err_len97", 64'(o_hdr_err), 64'(1'b1));
        chk("t4.no_beat0", 64'(o_vld), 64'(1'b0));
        idle();
        chk("t4.err_pulse", 64'(o_hdr_err), 64'(1'b0));
        chk("t4.no_beat1", 64'(o_vld), 64'(1'b0));
        chk("t4.drop", 64'(o_drop_cnt), 64'(16'd5));
        chk("t4.fields", 64'(w_fields), 64'(F3));

        // ---------------- LEN=96 (maximum), shift=1 ----------------
        cyc(1'b1, mk_hdr(F4, 7'd96));
        chk("t5.hdr_ok", 64'(o_hdr_err), 64'(1'b0));
        for (int k = 0; k < 96; k++) begin
            cyc(1'b1, mk_pl(14'(k), 14'h0000, 14'h0000, 14'h0000));
            if (k > 0) begin
                chk_beat($sformatf("t5.b%0d", k - 1), (k == 1), 1'b0,
                         {16'(2 * (k - 1)), 16'h0000}, 32'h0);
            end
        end
        idle();
        chk_beat("t5.b95", 1'b0, 1'b1, {16'd190, 16'h0000}, 32'h0);
        chk("t5.fields", 64'(w_fields), 64'(F4));
        idle();
        chk("t5.done", 64'(o_vld), 64'(1'b0));

        // ---------------- back-to-back with sync-like payload ----------------
        pa5 = {4'hA, 14'h1400, 14'h0010, 4'h0, 14'h0002, 14'h0003};
        cyc(1'b1, mk_hdr(F5A, 7'd2));
        cyc(1'b1, pa5);
        idle();
        chk_beat("t6.a0", 1'b1, 1'b0, {16'h1400, 16'h0010}, {16'h0002, 16'h0003});
        chk("t6.a_fields", 64'(w_fields), 64'(F5A));
        cyc(1'b1, pa5);
        chk("t6.gap", 64'(o_vld), 64'(1'b0));
        chk("t6.no_err", 64'(o_hdr_err), 64'(1'b0));
        cyc(1'b1, mk_hdr(F5B, 7'd2));
        chk_beat("t6.a1", 1'b0, 1'b1, {16'h1400, 16'h0010}, {16'h0002, 16'h0003});
        cyc(1'b1, pa5);
        chk("t6.ant_hold", 64'(o_ant_idx), 64'(2'd0));
        idle();
        chk_beat("t6.b0", 1'b1, 1'b0, {16'h1400, 16'h0010}, {16'h0002, 16'h0003});
        chk("t6.ant_switch", 64'(o_ant_idx), 64'(2'd3));
        chk("t6.b_fields", 64'(w_fields), 64'(F5B));
        cyc(1'b1, pa5);
        chk("t6.gap2", 64'(o_vld), 64'(1'b0));
        idle();
        chk_beat("t6.b1", 1'b0, 1'b1, {16'h1400, 16'h0010}, {16'h0002, 16'h0003});
        idle();
        chk("t6.done", 64'(o_vld), 64'(1'b0));
        chk("t6.drop", 64'(o_drop_cnt), 64'(16'd5));

        // ---------------- reset mid-packet ----------------
        cyc(1'b1, mk_hdr(F6, 7'd6));
        cyc(1'b1, mk_pl(14'h0011, 14'h0022, 14'h0033, 14'h0044));
        cyc(1'b1, mk_pl(14'h0055, 14'h0066, 14'h0077, 14'h0088));
        chk_beat("t7.b0", 1'b1, 1'b0, {16'h0011, 16'h0022}, {16'h0033, 16'h0044});
        cyc(1'b1, mk_pl(14'h0099, 14'h00AA, 14'h00BB, 14'h00CC));
        chk_beat("t7.b1", 1'b0, 1'b0, {16'h0055, 16'h0066}, {16'h0077, 16'h0088});
        #2;
        rst_n = 1'b0;
        i_iq_rx_valid = 1'b0;
        i_iq_rx_data  = '0;
        #1;
        chk("t7.rst_vld", 64'(o_vld), 64'(1'b0));
        chk("t7.rst_re0", 64'(o_re0), 64'(32'h0));
        chk("t7.rst_fields", 64'(w_fields), 64'(39'h0));
        chk("t7.rst_drop", 64'(o_drop_cnt), 64'(16'd0));
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("t7.flushed", 64'(o_vld), 64'(1'b0));
        idle();
        chk("t7.no_eop", 64'(o_eop), 64'(1'b0));
        cyc(1'b1, mk_pl(14'h0011, 14'h0022, 14'h0033, 14'h0044));
        chk("t7.hunt_drop", 64'(o_drop_cnt), 64'(16'd1));
        cyc(1'b1, mk_hdr(F6, 7'd1));
        cyc(1'b1, mk_pl(14'h0123, 14'h3ABC, 14'h0000, 14'h0001));
        idle();
        chk_beat("t7.new", 1'b1, 1'b1, {16'h0123, 16'hFABC}, {16'h0000, 16'h0001});
        chk("t7.fields", 64'(w_fields), 64'(F6));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
